// File: rtl/orion_types.sv
// ============================================================================
// Module      : orion_types
// Description : Shared widths, FSM state type and address range helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package orion_types;

  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

  // Evaluated at 64 bits so that BASE_ADDR + 4*DEPTH_WORDS cannot wrap.
  function automatic logic addr_in_range(input logic [ADDRW-1:0] addr,
                                         input logic [ADDRW-1:0] base,
                                         input int unsigned      depth_words);
    logic [63:0] lo;
    logic [63:0] hi;
    logic [63:0] a;
    lo = {{(64-ADDRW){1'b0}}, base};
    hi = lo + (64'd4 * 64'(depth_words));
    a  = {{(64-ADDRW){1'b0}}, addr};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/orion_sram_array.sv
// ============================================================================
// Module      : orion_sram_array
// Description : Single-port word array, synchronous read, per-byte write
//               enables, no reset on contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module orion_sram_array
  import orion_types::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [MASKW-1:0] be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < MASKW; b++) begin
          if (be_i[b]) begin
            r_mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[idx_i];
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Fixed-latency memory responder: request capture, latency
//               FSM, range check, backed by orion_sram_array.
//               Optional macro MEM_RESPONDER_OOR_ERR_EN drives err_o on
//               out-of-range accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
  import orion_types::*;
#(
  parameter logic [ADDRW-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int               DEPTH_WORDS = 4096,
  parameter int               LATENCY     = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic             valid_i,
  input  logic             we_i,
  input  logic [MASKW-1:0] mask_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  rdata_o,
  output logic             resp_o,
  output logic             err_o
);

  localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

  mem_resp_state_e  r_state;
  mem_resp_state_e  w_next;
  logic [3:0]       r_cnt;
  logic [ADDRW-1:0] r_addr;
  logic             r_we;
  logic [MASKW-1:0] r_mask;
  logic [XLEN-1:0]  r_wdata;
  logic             r_oor;
  logic [XLEN-1:0]  r_rdata_hold;

  logic             w_accept;
  logic             w_fire;
  logic [ADDRW-1:0] w_acc_addr;
  logic             w_acc_we;
  logic [MASKW-1:0] w_acc_mask;
  logic [XLEN-1:0]  w_acc_wdata;
  logic             w_in_range;
  logic [ADDRW-1:0] w_offset;
  logic [c_idx_w-1:0] w_idx;
  logic [XLEN-1:0]  w_sram_q;
  logic [XLEN-1:0]  w_resp_rdata;

  assign w_accept = (r_state == IDLE) && valid_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The array is accessed on the edge entering RESP; with LATENCY=1 that is
  // the acceptance edge itself, so the live request inputs are used there.
  assign w_fire      = (w_next == RESP) && !rst_i;
  assign w_acc_addr  = (r_state == IDLE) ? addr_i  : r_addr;
  assign w_acc_we    = (r_state == IDLE) ? we_i    : r_we;
  assign w_acc_mask  = (r_state == IDLE) ? mask_i  : r_mask;
  assign w_acc_wdata = (r_state == IDLE) ? wdata_i : r_wdata;
  assign w_in_range  = addr_in_range(w_acc_addr, BASE_ADDR, DEPTH_WORDS);
  assign w_offset    = w_acc_addr - BASE_ADDR;
  assign w_idx       = c_idx_w'(w_offset >> 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_mask       <= '0;
      r_wdata      <= '0;
      r_oor        <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= addr_i;
        r_we    <= we_i;
        r_mask  <= mask_i;
        r_wdata <= wdata_i;
        r_cnt   <= c_cnt_load;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire) begin
        r_oor <= !w_in_range;
      end
      if (resp_o && !r_we) begin
        r_rdata_hold <= w_resp_rdata;
      end
    end
  end

  orion_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_idx_w)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (w_fire && w_in_range),
    .we_i    (w_acc_we),
    .be_i    (w_acc_mask),
    .idx_i   (w_idx),
    .wdata_i (w_acc_wdata),
    .rdata_o (w_sram_q)
  );

  assign resp_o       = (r_state == RESP);
  assign w_resp_rdata = r_oor ? '0 : w_sram_q;
  // Outside a read response the last returned word is presented unchanged.
  assign rdata_o      = (resp_o && !r_we) ? w_resp_rdata : r_rdata_hold;

`ifdef MEM_RESPONDER_OOR_ERR_EN
  assign err_o = resp_o && r_oor;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench; four responders at LATENCY 1/3/4/5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int LATS [4] = '{1, 3, 4, 5};
`ifdef MEM_RESPONDER_OOR_ERR_EN
  localparam logic OOR_ERR = 1'b1;
`else
  localparam logic OOR_ERR = 1'b0;
`endif

  typedef struct {
    int          d;
    int          cyc;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] addr  [4];
  logic        valid [4];
  logic        we    [4];
  logic [3:0]  mask  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        resp  [4];
  logic        err   [4];

  int   cyc;
  int   total;
  int   bad;
  exp_t sb [$];
  logic prev_resp [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    mem_responder #(
      .BASE_ADDR   (32'h8000_0000),
      .DEPTH_WORDS (4096),
      .LATENCY     (LATS[k])
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .addr_i  (addr[k]),
      .valid_i (valid[k]),
      .we_i    (we[k]),
      .mask_i  (mask[k]),
      .wdata_i (wdata[k]),
      .rdata_o (rdata[k]),
      .resp_o  (resp[k]),
      .err_o   (err[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one request, push its expectation, return in the cycle after resp.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input bit flush);
    exp_t e;
    addr[d]  = a;
    we[d]    = w;
    mask[d]  = m;
    wdata[d] = wd;
    valid[d] = 1'b1;
    e.d = d; e.cyc = cyc + LATS[d]; e.we = w; e.rdata = er; e.err = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    if (flush) valid[d] = 1'b0;
    repeat (LATS[d]) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever any responder pulses resp_o.
  initial begin
    exp_t e;
    for (int k = 0; k < 4; k++) prev_resp[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (resp[k] === 1'b1) begin
          check($sformatf("gap_dut%0d", k), {31'b0, prev_resp[k]}, 32'd0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_resp dut%0d: got resp=1 want none (cycle %0d)", k, cyc);
          end else begin
            e = sb.pop_front();
            check("resp_dut", k, e.d);
            check($sformatf("resp_cycle_dut%0d", k), cyc, e.cyc);
            if (!e.we) check($sformatf("rdata_dut%0d", k), rdata[k], e.rdata);
            check($sformatf("err_dut%0d", k), {31'b0, err[k]}, {31'b0, e.err});
          end
        end
        prev_resp[k] = resp[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; total = 0; bad = 0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr[k] = '0; valid[k] = 1'b0; we[k] = 1'b0; mask[k] = '0; wdata[k] = '0;
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_resp_dut%0d", k), {31'b0, resp[k]}, 32'd0);
      check($sformatf("rst_err_dut%0d", k), {31'b0, err[k]}, 32'd0);
      check($sformatf("rst_rdata_dut%0d", k), rdata[k], 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1: preload, read, read-after-write, byte-offset, mask 0
    issue(0, 1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, 0);
    issue(0, 0, 32'h8000_0010, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    issue(0, 0, 32'h8000_0013, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
    issue(0, 1, 32'h8000_0010, 4'h0, 32'h0000_0000, 0, 1'b0, 0);
    issue(0, 0, 32'h8000_0010, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    // Range boundaries; an OOR write must not alias onto word 0
    issue(0, 1, 32'h8000_0000, 4'hF, 32'h0102_0304, 0, 1'b0, 0);
    issue(0, 1, 32'h8000_3FFC, 4'hF, 32'h5A5A_1234, 0, 1'b0, 0);
    issue(0, 0, 32'h7FFF_FFFC, 4'hF, 0, 32'h0, OOR_ERR, 0);
    issue(0, 0, 32'h8000_4000, 4'hF, 0, 32'h0, OOR_ERR, 0);
    issue(0, 1, 32'h8000_4000, 4'hF, 32'hFFFF_FFFF, 0, OOR_ERR, 0);
    issue(0, 0, 32'h8000_0000, 4'hF, 0, 32'h0102_0304, 1'b0, 0);
    issue(0, 0, 32'h8000_3FFC, 4'hF, 0, 32'h5A5A_1234, 1'b0, 0);
    valid[0] = 1'b0;

    // LATENCY=3: byte-masked write, then back-to-back reads with valid held
    issue(1, 1, 32'h8000_0000, 4'hF, 32'h1122_3344, 0, 1'b0, 0);
    issue(1, 1, 32'h8000_0000, 4'b0101, 32'hAABB_CCDD, 0, 1'b0, 0);
    issue(1, 0, 32'h8000_0000, 4'h0, 0, 32'h11BB_33DD, 1'b0, 0);
    issue(1, 1, 32'h8000_0004, 4'b1010, 32'hCAFE_BABE, 0, 1'b0, 0);
    issue(1, 0, 32'h8000_0000, 4'hF, 0, 32'h11BB_33DD, 1'b0, 0);
    valid[1] = 1'b0;

    // LATENCY=4: initiator flush one cycle after a write acceptance
    issue(2, 1, 32'h8000_0020, 4'hF, 32'hCAFE_F00D, 0, 1'b0, 1);
    issue(2, 0, 32'h8000_0020, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 0);
    valid[2] = 1'b0;

    // LATENCY=5: reset during WAIT drops an uncommitted write
    issue(3, 1, 32'h8000_0040, 4'hF, 32'h1234_5678, 0, 1'b0, 0);
    issue(3, 0, 32'h8000_0040, 4'hF, 0, 32'h1234_5678, 1'b0, 0);
    addr[3] = 32'h8000_0040; we[3] = 1'b1; mask[3] = 4'hF; wdata[3] = 32'h0000_9999;
    valid[3] = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    valid[3] = 1'b0;
    #1;
    check("async_rst_resp", {31'b0, resp[3]}, 32'd0);
    check("async_rst_rdata", rdata[3], 32'd0);
    check("async_rst_err", {31'b0, err[3]}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    issue(3, 0, 32'h8000_0040, 4'hF, 0, 32'h1234_5678, 1'b0, 0);
    valid[3] = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("pending_expectations", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, number of XLEN-bit words; power of two.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..15; cycles from acceptance to resp_o.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port addr_i, input, ADDRW, request byte address.
REQ-007 SHALL have port valid_i, input, 1, request present; initiator holds all request inputs stable until resp_o.
REQ-008 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port mask_i, input, MASKW, byte write enables; bit i covers byte i.
REQ-010 SHALL have port wdata_i, input, XLEN, write data.
REQ-011 SHALL have port rdata_o, output, XLEN, read data; valid only while resp_o=1.
REQ-012 SHALL have port resp_o, output, 1, single-cycle completion pulse.
REQ-013 SHALL have port err_o, output, 1, out-of-range flag, qualified by resp_o.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE with valid_i=1 at a rising edge (acceptance, cycle t0), SHALL capture addr_i, we_i, mask_i and wdata_i, then load the latency counter with LATENCY-1.
REQ-016 On acceptance, SHALL go to RESP when LATENCY=1 and to WAIT otherwise.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-018 SHALL assert resp_o only in RESP, for exactly one cycle, in cycle t0+LATENCY; RESP SHALL always return to IDLE.
REQ-019 SHALL NOT accept a request in the RESP cycle; the earliest next acceptance is at t0+LATENCY+1.
REQ-020 SHALL compute the word index as (addr - BASE_ADDR) >> 2, ignoring addr[1:0].
REQ-021 An access is in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, computed without wrap-around.
REQ-022 An in-range write SHALL update only the bytes whose mask bit is set, on the edge entering RESP; mask 0 SHALL leave the word unchanged.
REQ-023 An in-range read SHALL return the full word, ignoring mask_i, sampled on the edge entering RESP.
REQ-024 A read issued on the cycle after a write's resp_o SHALL return the newly written data.
REQ-025 If valid_i drops after acceptance (initiator flush), the captured transaction SHALL still complete, including the write and resp_o.
REQ-026 rdata_o SHALL hold its last value outside RESP; the initiator ignores it there.

Reset
REQ-027 rst_i SHALL force IDLE, counter=0, resp_o=0, err_o=0 and rdata_o=0 immediately, regardless of clock.
REQ-028 Reset SHALL NOT clear array contents; a transaction in flight is dropped and its write is not committed unless the commit edge preceded reset.

Configuration
REQ-029 With macro MEM_RESPONDER_OOR_ERR_EN defined, an out-of-range access SHALL assert err_o with resp_o, return rdata_o=0 for reads, and drop writes.
REQ-030 Without MEM_RESPONDER_OOR_ERR_EN, err_o SHALL be tied 0; out-of-range reads SHALL return 0 and writes SHALL be silently dropped, with resp_o timing unchanged.

Structure
REQ-031 ADDRW, XLEN and MASKW SHALL come from orion_types.
REQ-032 The FSM enum mem_resp_state_e SHALL be added to orion_types.
REQ-033 Storage SHALL live in sub-module orion_sram_array: single-port, synchronous read, per-byte write enables, no reset.
REQ-034 mem_responder SHALL contain the FSM, counter, request capture and range check.

Verification
REQ-035 LATENCY=1, read of 0x8000_0010 preloaded with 0xDEADBEEF -> resp_o=1 exactly one cycle after acceptance, rdata_o=0xDEADBEEF, err_o=0.
REQ-036 LATENCY=3: write 0xAABBCCDD with mask 4'b0101 to 0x8000_0000 (old 0x11223344), then read the same address -> each resp_o 3 cycles after acceptance, read returns 0x11BB33DD.
REQ-037 Back-to-back reads with valid_i held high -> exactly one resp_o per request and an IDLE gap cycle between transactions; never two consecutive resp_o cycles.
REQ-038 Flush case: valid_i drops one cycle after a write acceptance at LATENCY=4 -> resp_o still pulses at t0+4 and the write is visible to the next read.
REQ-039 Read of 0x7FFF_FFFC and of 0x8000_4000 (DEPTH_WORDS=4096) -> rdata_o=0; err_o=1 with MEM_RESPONDER_OOR_ERR_EN defined and 0 without.
REQ-040 rst_i asserted asynchronously during WAIT at LATENCY=5 -> resp_o=0 immediately, no resp_o afterwards, next request after reset served normally.
